// File: rtl/cs161_mc_control.sv
// cs161 multi-cycle MIPS control unit.
// Moore FSM driving datapath strobes, with retire counter and illegal-op halt.
module cs161_mc_control #(
  parameter int         CNT_WIDTH   = 32,
  parameter logic [3:0] ALUOP_ADD   = 4'b0000,
  parameter logic [3:0] ALUOP_SUB   = 4'b0001,
  parameter logic [3:0] ALUOP_FUNCT = 4'b0010
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           instr_op,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic [1:0]           pc_source,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [3:0]           alu_op,
  output logic                 illegal_op,
  output logic [CNT_WIDTH-1:0] retired,
  output logic [3:0]           state_dbg
);

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADI = 6'h08;
  localparam logic [5:0] OP_J   = 6'h02;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_JUMP      = 4'd12,
    S_HALT      = 4'd13
  } state_t;

  state_t     state;
  logic [5:0] op_q;
  logic       retire;

  always_comb begin
    retire = 1'b0;
    case (state)
      S_MEM_WB, S_R_WB, S_BRANCH,
      S_I_WB, S_JUMP: retire = 1'b1;
      S_MEM_WRITE:    retire = mem_ready;
      default:        retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= '0;
      retired <= '0;
    end else begin
      if (retire)
        retired <= retired + CNT_WIDTH'(1);
      case (state)
        S_IDLE:  state <= S_FETCH;
        S_FETCH: if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          op_q <= instr_op;
          case (instr_op)
            OP_R:         state <= S_R_EXEC;
            OP_LW, OP_SW: state <= S_MEM_ADDR;
            OP_BEQ:       state <= S_BRANCH;
            OP_ADI:       state <= S_I_EXEC;
            OP_J:         state <= S_JUMP;
            default:      state <= S_HALT;
          endcase
        end
        S_MEM_ADDR:
          state <= (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (mem_ready) state <= S_MEM_WB;
        S_MEM_WB:    state <= S_FETCH;
        S_MEM_WRITE: if (mem_ready) state <= S_FETCH;
        S_R_EXEC:    state <= S_R_WB;
        S_R_WB:      state <= S_FETCH;
        S_BRANCH:    state <= S_FETCH;
        S_I_EXEC:    state <= S_I_WB;
        S_I_WB:      state <= S_FETCH;
        S_JUMP:      state <= S_FETCH;
        S_HALT:      state <= S_HALT;
        default:     state <= S_IDLE;
      endcase
    end
  end

  // FETCH strobes follow mem_ready so IR/PC load only on the completing cycle
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 4'b0000;
    illegal_op    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALUOP_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_I_WB:  reg_write = 1'b1;
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_HALT:  illegal_op = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_cs161_mc_control.sv
// Scoreboard bench for cs161_mc_control.
// Instruction-level model predicts per-cycle state, strobes and retire count.
module tb_cs161_mc_control;

  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [5:0]    instr_op;
  logic          mem_ready;
  logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic          ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic          illegal_op;
  logic [1:0]    pc_source, alu_src_b;
  logic [3:0]    alu_op, state_dbg;
  logic [CW-1:0] retired;

  cs161_mc_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .instr_op(instr_op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal_op(illegal_op),
    .retired(retired), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit            chk;
    logic [3:0]    st;
    logic [18:0]   o;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            failures = 0;
  int            ncyc = 0;
  logic [CW-1:0] m_ret = '0;

  // Strobe table: {pw,pwc,ps,iod,mrd,mwr,irw,m2r,rdst,rw,asa,asb,aop,ill}
  function automatic logic [18:0] exp_out(input logic [3:0] st,
                                          input logic mr);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, ill;
    logic [1:0] ps, asb;
    logic [3:0] aop;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, ill} = '0;
    ps = 2'b00; asb = 2'b00; aop = 4'b0000;
    case (st)
      4'd1:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      4'd2:  asb = 2'b11;
      4'd3:  begin asa = 1; asb = 2'b10; end
      4'd4:  begin mrd = 1; iod = 1; end
      4'd5:  begin rw = 1; m2r = 1; end
      4'd6:  begin mwr = 1; iod = 1; end
      4'd7:  begin asa = 1; aop = 4'b0010; end
      4'd8:  begin rw = 1; rdst = 1; aop = 4'b0010; end
      4'd9:  begin asa = 1; aop = 4'b0001; pwc = 1; ps = 2'b01; end
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd11: rw = 1;
      4'd12: begin pw = 1; ps = 2'b10; end
      4'd13: ill = 1;
      default: ;
    endcase
    return {pw, pwc, ps, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb,
            aop, ill};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [18:0] got;
    if (q.size() > 0) begin
      e = q.pop_front();
      ncyc++;
      if (e.chk) begin
        got = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read,
               mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
               alu_src_a, alu_src_b, alu_op, illegal_op};
        checks++;
        if (state_dbg !== e.st) begin
          failures++;
          $display("FAIL state cyc=%0d got=%0d exp=%0d",
                   ncyc, state_dbg, e.st);
        end
        checks++;
        if (got !== e.o) begin
          failures++;
          $display("FAIL outputs cyc=%0d st=%0d got=%b exp=%b",
                   ncyc, e.st, got, e.o);
        end
        checks++;
        if (retired !== e.ret) begin
          failures++;
          $display("FAIL retired cyc=%0d got=%0d exp=%0d",
                   ncyc, retired, e.ret);
        end
        checks++;
        if (int'(reg_write) + int'(mem_write) + int'(pc_write) > 1) begin
          failures++;
          $display("FAIL exclusive cyc=%0d rw=%b mw=%b pw=%b exp=at_most_one",
                   ncyc, reg_write, mem_write, pc_write);
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic mr, input logic [5:0] op,
                     input bit chk, input logic [3:0] st);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    mem_ready = mr;
    instr_op  = op;
    e.chk = chk;
    e.st  = st;
    e.o   = exp_out(st, mr);
    e.ret = m_ret;
    q.push_back(e);
  endtask

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic logic rmr();
    return 1'($urandom);
  endfunction

  // Reset asserted during a cycle whose state is cur; IDLE follows.
  task automatic rst_cycle(input logic [3:0] cur, input bit chk);
    cyc(1'b1, rmr(), rop(), chk, cur);
    m_ret = '0;
    cyc(1'b0, rmr(), rop(), 1'b1, 4'd0);
  endtask

  task automatic mem_wait(input logic [3:0] st, input int w);
    for (int i = 0; i < w; i++) cyc(1'b0, 1'b0, rop(), 1'b1, st);
    cyc(1'b0, 1'b1, rop(), 1'b1, st);
  endtask

  task automatic front(input logic [5:0] op, input int wf);
    mem_wait(4'd1, wf);
    cyc(1'b0, rmr(), op, 1'b1, 4'd2);
  endtask

  task automatic run_instr(input logic [5:0] op, input int wf,
                           input int wm);
    front(op, wf);
    case (op)
      6'h00: begin
        cyc(1'b0, rmr(), rop(), 1'b1, 4'd7);
        cyc(1'b0, rmr(), rop(), 1'b1, 4'd8);
      end
      6'h23: begin
        cyc(1'b0, rmr(), rop(), 1'b1, 4'd3);
        mem_wait(4'd4, wm);
        cyc(1'b0, rmr(), rop(), 1'b1, 4'd5);
      end
      6'h2B: begin
        cyc(1'b0, rmr(), rop(), 1'b1, 4'd3);
        mem_wait(4'd6, wm);
      end
      6'h04: cyc(1'b0, rmr(), rop(), 1'b1, 4'd9);
      6'h08: begin
        cyc(1'b0, rmr(), rop(), 1'b1, 4'd10);
        cyc(1'b0, rmr(), rop(), 1'b1, 4'd11);
      end
      6'h02: cyc(1'b0, rmr(), rop(), 1'b1, 4'd12);
      default: begin
        for (int i = 0; i < 20; i++) cyc(1'b0, rmr(), rop(), 1'b1, 4'd13);
        rst_cycle(4'd13, 1'b1);
        return;
      end
    endcase
    m_ret = m_ret + 1'b1;
  endtask

  // lw aborted by reset while MEM_READ is still waiting
  task automatic lw_abort(input int wf, input int wm);
    front(6'h23, wf);
    cyc(1'b0, rmr(), rop(), 1'b1, 4'd3);
    for (int i = 0; i < wm; i++) cyc(1'b0, 1'b0, rop(), 1'b1, 4'd4);
    rst_cycle(4'd4, 1'b1);
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
  endfunction

  initial begin
    logic [5:0] ops[6];
    logic [5:0] op;
    int         k;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    rst = 1'b1;
    mem_ready = 1'b0;
    instr_op = 6'h00;
    cyc(1'b1, 1'b0, 6'h00, 1'b0, 4'd0);
    cyc(1'b1, 1'b1, 6'h00, 1'b1, 4'd0);
    cyc(1'b0, 1'b1, 6'h00, 1'b1, 4'd0);
    foreach (ops[i]) run_instr(ops[i], 0, 0);
    run_instr(6'h23, 3, 2);
    run_instr(6'h2B, 0, 4);
    run_instr(6'h3F, 1, 0);
    for (int i = 0; i < 17; i++) run_instr(6'h02, 0, 0);
    run_instr(6'h08, 0, 0);
    lw_abort(1, 2);
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 11);
      if (k < 6) op = ops[k];
      else if (k < 11) op = ops[$urandom_range(0, 5)];
      else begin
        op = rop();
        while (legal(op)) op = rop();
      end
      if ($urandom_range(0, 15) == 0) lw_abort($urandom_range(0, 3),
                                               $urandom_range(0, 3));
      else run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cs161_mc_control.md
Name: cs161_mc_control

Overview:
Multi-cycle control unit for the cs161 MIPS datapath. It consumes the decoded opcode and drives every datapath control strobe through a Moore state machine, one phase per cycle, and stalls on memory handshakes. It also exposes a retired-instruction counter, an illegal-opcode halt and the current state for debug.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter
ALUOP_ADD, 4'b0000, alu_op code for add
ALUOP_SUB, 4'b0001, alu_op code for subtract
ALUOP_FUNCT, 4'b0010, alu_op code meaning "decode funct field"

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
instr_op  in  6  opcode from instruction register
mem_ready  in  1  memory completed current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
pc_source  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
i_or_d  out  1  0 memory address = PC, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
mem_to_reg  out  1  1 selects memory data for register write
reg_dst  out  1  1 selects instr[15:11], 0 selects instr[20:16]
reg_write  out  1  register file write enable
alu_src_a  out  1  0 PC, 1 register A
alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op  out  4  ALU operation code
illegal_op  out  1  sticky; unsupported opcode decoded
retired  out  CNT_WIDTH  count of completed instructions
state_dbg  out  4  current state encoding

Behaviour:
- State register + op_q (6b) + retired counter are the only flops. Outputs are pure decode of the current state (Moore); in states not listed, every output is 0.
- Encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, R_EXEC 7, R_WB 8, BRANCH 9, I_EXEC 10, I_WB 11, JUMP 12, HALT 13. Codes 14-15 are unreachable and go to IDLE.
- Reset (rst=1 at an edge, in any state including a mem wait): state=IDLE, op_q=0, retired=0, illegal_op=0. All outputs are 0 in IDLE. IDLE goes to FETCH unconditionally.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00. ir_write and pc_write both equal mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD. op_q<=instr_op. Next state by instr_op:
  - 0x00 goes to R_EXEC.
  - 0x23 and 0x2B go to MEM_ADDR.
  - 0x04 goes to BRANCH.
  - 0x08 goes to I_EXEC.
  - 0x02 goes to JUMP.
  - Any other opcode goes to HALT.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Goes to MEM_READ if op_q=0x23, else MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Strobe stays high while waiting. On mem_ready goes to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=FUNCT. Goes to R_WB.
- R_WB: reg_write=1, reg_dst=1, alu_op=FUNCT. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_write_cond=1, pc_source=01. Goes to FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=ADD. Goes to I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- JUMP: pc_write=1, pc_source=10. Goes to FETCH.
- HALT: all strobes 0, illegal_op=1. Stays in HALT until rst.
- Retire events are leaving MEM_WB, R_WB, BRANCH, I_WB or JUMP, and leaving MEM_WRITE with mem_ready=1. Each event increments retired by 1 at that edge; the counter wraps modulo 2^CNT_WIDTH.
- Latency with mem_ready tied 1, counting states from FETCH inclusive: lw 5, sw/R/addi 4, beq/j 3.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- reg_write, mem_write and pc_write never assert together in one cycle.

Test Plan:
- rst=1 for 2 cycles, then release → state_dbg 0 then 1; all outputs 0 during reset; retired=0.
- mem_ready=1, op sequence 0x00, 0x23, 0x2B, 0x04, 0x02, 0x08 → state paths 1-2-7-8, 1-2-3-4-5, 1-2-3-6, 1-2-9, 1-2-12, 1-2-10-11; retired=6 after 23 cycles of FETCH-onward; per-state output values as in Behaviour.
- lw with mem_ready low 3 cycles in FETCH and 2 in MEM_READ → lw takes 10 cycles; ir_write/pc_write pulse exactly once; mem_read held throughout the waits.
- sw with mem_ready low 4 cycles in MEM_WRITE → mem_write high for 5 consecutive cycles; retired increments only on the ready edge.
- op 0x3F in DECODE → HALT (13), illegal_op=1, stays 20 cycles regardless of mem_ready; rst clears to IDLE, illegal_op=0.
- CNT_WIDTH=4, 17 back-to-back j → retired wraps 15 to 0 to 1; rst asserted in MEM_READ mid-wait → IDLE next edge, no reg_write issued.
